fifo_buffer_sync: RTL and testbench

//   Single-clock first-word-fall-through (FWFT) byte FIFO between two PicoBlaze (kcpsm6) processors.

---
 rtl/fifo_buffer_sync.sv | 104 ++++++++++
 tb/tb_fifo_buffer_sync.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/fifo_buffer_sync.sv
// rtl/fifo_buffer_sync.sv - single-clock FWFT byte FIFO; sticky overflow/underflow flags under FIFO_BUFFER_ERR_FLAGS_EN
module fifo_buffer_sync #(
    parameter int DEPTH        = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int AFULL_LEVEL  = 14,
    parameter int AEMPTY_LEVEL = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [DATA_WIDTH-1:0]      din,
    input  logic                       rd_en,
    output logic [DATA_WIDTH-1:0]      dout,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    input  logic                       err_clr,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LEVEL);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  wr_accept, rd_accept;

    // Status is decoded from the registered count only, so it never glitches on input strobes.
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AFULL_C);
    assign almost_empty = (count_q <= AEMPTY_C);
    assign count        = count_q;

    assign wr_accept = wr_en && (!full || rd_en);
    assign rd_accept = rd_en && !empty;

    assign dout = empty ? '0 : mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_accept) rd_ptr_d = rd_ptr_q + 1'b1;
        if (wr_accept && !rd_accept)      count_d = count_q + 1'b1;
        else if (rd_accept && !wr_accept) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) mem[wr_ptr_q] <= din;
    end

`ifdef FIFO_BUFFER_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // A new error in the same cycle as err_clr must survive the clear.
    always_comb begin
        overflow_d  = err_clr ? 1'b0 : overflow_q;
        underflow_d = err_clr ? 1'b0 : underflow_q;
        if (wr_en && full && !rd_en) overflow_d  = 1'b1;
        if (rd_en && empty)          underflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_buffer_sync.sv
// tb/tb_fifo_buffer_sync.sv - directed and random checks of fifo_buffer_sync against a queue model
module tb_fifo_buffer_sync;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] din = 8'h00;
    logic       rd_en = 1'b0;
    logic [7:0] dout;
    logic       full, empty, almost_full, almost_empty;
    logic [4:0] count;
    logic       err_clr = 1'b0;
    logic       overflow, underflow;

    int checks = 0;
    int failures = 0;

    logic [7:0] q[$];
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;

`ifdef FIFO_BUFFER_ERR_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    fifo_buffer_sync #(.DEPTH(16), .DATA_WIDTH(8), .AFULL_LEVEL(14), .AEMPTY_LEVEL(2)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(dout),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .err_clr(err_clr), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n = q.size();
        chk({tag, ".count"},  32'(count), 32'(n));
        chk({tag, ".empty"},  32'(empty), 32'(n == 0));
        chk({tag, ".full"},   32'(full),  32'(n == DEPTH));
        chk({tag, ".afull"},  32'(almost_full),  32'(n >= 14));
        chk({tag, ".aempty"}, 32'(almost_empty), 32'(n <= 2));
        chk({tag, ".dout"},   32'(dout), (n == 0) ? 32'h0 : 32'(q[0]));
        chk({tag, ".ovf"},    32'(overflow),  32'(m_ovf));
        chk({tag, ".unf"},    32'(underflow), 32'(m_unf));
    endtask

    // Model updated at the clock edge from the pre-edge occupancy.
    task automatic cycle(input string tag, input logic wr, input logic [7:0] d,
                         input logic rd, input logic clr);
        int  n;
        bit  do_wr, do_rd, set_o, set_u;
        wr_en = wr; din = d; rd_en = rd; err_clr = clr;
        @(posedge clk);
        n     = q.size();
        do_wr = wr && (n < DEPTH || rd);
        do_rd = rd && (n > 0);
        set_o = wr && (n == DEPTH) && !rd;
        set_u = rd && (n == 0);
        if (do_rd) void'(q.pop_front());
        if (do_wr) q.push_back(d);
        if (FLAGS_ON) begin
            m_ovf = set_o ? 1'b1 : (clr ? 1'b0 : m_ovf);
            m_unf = set_u ? 1'b1 : (clr ? 1'b0 : m_unf);
        end
        #1;
        wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #2;
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        check_all(tag);
        rst_n = 1'b1;
    endtask

    initial begin
        #1;
        do_reset("reset");
        chk("reset.dout0", 32'(dout), 32'h0);

        cycle("wr_a5", 1'b1, 8'hA5, 1'b0, 1'b0);
        chk("wr_a5.dout_const", 32'(dout), 32'hA5);
        cycle("rd_a5", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("rd_a5.empty_const", 32'(empty), 32'h1);

        for (int i = 0; i < 16; i++) cycle("fill", 1'b1, 8'(i), 1'b0, 1'b0);
        chk("fill.full_const", 32'(full), 32'h1);
        cycle("wr17", 1'b1, 8'hEE, 1'b0, 1'b0);
        chk("wr17.ovf_const", 32'(overflow), 32'(FLAGS_ON));
        for (int i = 0; i < 16; i++) begin
            chk("drain.order", 32'(dout), 32'(i));
            cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);
        end

        for (int i = 0; i < 10; i++) cycle("wrap_w1", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle("wrap_r1", 1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) cycle("wrap_w2", 1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            chk("wrap.order", 32'(dout), 32'(8'h80 + i));
            cycle("wrap_r2", 1'b0, 8'h00, 1'b1, 1'b0);
        end

        for (int i = 0; i < 16; i++) cycle("fill2", 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        cycle("both_full", 1'b1, 8'h5A, 1'b1, 1'b0);
        chk("both_full.count_const", 32'(count), 32'd16);
        for (int i = 0; i < 15; i++) cycle("pop15", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("pop15.newbyte", 32'(dout), 32'h5A);
        cycle("pop_last", 1'b0, 8'h00, 1'b1, 1'b0);
        cycle("both_empty", 1'b1, 8'h33, 1'b1, 1'b0);
        chk("both_empty.count_const", 32'(count), 32'd1);
        chk("both_empty.unf_const", 32'(underflow), 32'(FLAGS_ON));

        cycle("err_clr", 1'b0, 8'h00, 1'b0, 1'b1);
        chk("err_clr.ovf_const", 32'(overflow), 32'h0);
        chk("err_clr.unf_const", 32'(underflow), 32'h0);
        cycle("rd_clr_same", 1'b0, 8'h00, 1'b1, 1'b0);
        cycle("set_wins", 1'b0, 8'h00, 1'b1, 1'b1);

        for (int i = 0; i < 400; i++) begin
            logic w, r, c;
            w = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 45);
            c = ($urandom_range(0, 99) < 5);
            cycle("rand", w, 8'($urandom), r, c);
        end

        for (int i = 0; i < 5; i++) cycle("pre_rst", 1'b1, 8'($urandom), 1'b0, 1'b0);
        do_reset("mid_reset");
        cycle("post_rst", 1'b1, 8'h77, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
